// File: rtl/cnn_pkg.sv
// Shared types and defaults for the layer sequencer.
// State encoding plus default bus widths, gap length and watchdog limit.
package cnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_ERR  = 2'd3
    } seq_state_t;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_GAP_CYCLES = 4;
    localparam int DEF_TIMEOUT    = 65535;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_seq_ctrl_if.sv
// Feature-buffer write port: host write request in, muxed buffer write out.
// master = host/buffer side, slave = sequencer side.
interface layer_seq_ctrl_if
    import cnn_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_din;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_din;

    modport master (
        output host_we, host_addr, host_din,
        input  buf_we, buf_addr, buf_din
    );

    modport slave (
        input  host_we, host_addr, host_din,
        output buf_we, buf_addr, buf_din
    );

endinterface

// File: rtl/seq_wdog.sv
// Per-layer watchdog: counts enabled cycles since the last clear.
// tc rises on the TIMEOUT-th enabled cycle.
module seq_wdog
    import cnn_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CW-1:0] cnt;

    assign tc = enable && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/layer_seq_ctrl.sv
// Sequences NUM_LAYERS engines in order with idle gaps and a watchdog,
// and muxes the host or the active engine onto the feature-buffer port.
module layer_seq_ctrl
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    localparam int LW = idx_w(NUM_LAYERS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    layer_seq_ctrl_if.slave              bus,
    input  logic [NUM_LAYERS-1:0]        eng_we,
    input  logic [ADDR_W*NUM_LAYERS-1:0] eng_addr,
    input  logic [DATA_W*NUM_LAYERS-1:0] eng_din,
    input  logic [NUM_LAYERS-1:0]        layer_fin,
    output logic [NUM_LAYERS-1:0]        layer_en,
    output logic [LW-1:0]                cur_layer,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         host_drop
);

    localparam int GW = idx_w(GAP_CYCLES);

    seq_state_t            state;
    logic [GW-1:0]         gap_cnt;
    logic [NUM_LAYERS-1:0] cur_oh;
    logic                  in_run;
    logic                  fin_cur;
    logic                  fin_bad;
    logic                  last;
    logic                  wd_tc;

    assign in_run  = (state == S_RUN);
    assign cur_oh  = NUM_LAYERS'(1) << cur_layer;
    assign fin_cur = |(layer_fin & cur_oh);
    assign fin_bad = |(layer_fin & ~cur_oh);
    assign last    = (cur_layer == LW'(NUM_LAYERS - 1));

    // Held clear outside RUN, so every RUN entry starts from zero.
    seq_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_run),
        .enable (in_run),
        .tc     (wd_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur_layer <= '0;
            gap_cnt   <= '0;
            layer_en  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            host_drop <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.host_we && state != S_IDLE) begin
                host_drop <= 1'b1;
            end
            if (abort) begin
                state     <= S_IDLE;
                cur_layer <= '0;
                gap_cnt   <= '0;
                layer_en  <= '0;
                busy      <= 1'b0;
                err       <= 1'b0;
                host_drop <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !bus.host_we) begin
                            state     <= S_RUN;
                            cur_layer <= '0;
                            layer_en  <= NUM_LAYERS'(1);
                            busy      <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (fin_bad || (!fin_cur && wd_tc)) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            layer_en <= '0;
                            busy     <= 1'b0;
                        end else if (fin_cur) begin
                            layer_en <= '0;
                            gap_cnt  <= '0;
                            if (last) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                            state     <= S_RUN;
                            cur_layer <= cur_layer + 1'b1;
                            layer_en  <= NUM_LAYERS'(1)
                                         << (cur_layer + LW'(1));
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    S_ERR: begin
                        layer_en <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Address/data only move on an accepted write, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.buf_we   <= 1'b0;
            bus.buf_addr <= '0;
            bus.buf_din  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    bus.buf_we <= bus.host_we;
                    if (bus.host_we) begin
                        bus.buf_addr <= bus.host_addr;
                        bus.buf_din  <= bus.host_din;
                    end
                end
                S_RUN: begin
                    bus.buf_we <= eng_we[cur_layer];
                    if (eng_we[cur_layer]) begin
                        bus.buf_addr <=
                            eng_addr[int'(cur_layer)*ADDR_W +: ADDR_W];
                        bus.buf_din  <=
                            eng_din[int'(cur_layer)*DATA_W +: DATA_W];
                    end
                end
                default: begin
                    bus.buf_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: random engine/host traffic checked against a
// timeline model built from layer durations and the gap length.
module tb_layer_seq_ctrl;

    localparam int NL  = 3;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int GAP = 4;
    localparam int TO  = 1000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [NL-1:0]   eng_we = '0;
    logic [AW*NL-1:0] eng_addr = '0;
    logic [DW*NL-1:0] eng_din = '0;
    logic [NL-1:0]   layer_fin = '0;
    logic [NL-1:0]   layer_en;
    logic [1:0]      cur_layer;
    logic            busy;
    logic            done;
    logic            err;
    logic            host_drop;

    int total = 0;
    int bad = 0;

    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;
    logic          exp_drop = 1'b0;

    int rs[NL];
    int rd[NL];
    int r_end;

    layer_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    layer_seq_ctrl #(
        .NUM_LAYERS (NL),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .bus       (bus),
        .eng_we    (eng_we),
        .eng_addr  (eng_addr),
        .eng_din   (eng_din),
        .layer_fin (layer_fin),
        .layer_en  (layer_en),
        .cur_layer (cur_layer),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .host_drop (host_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Timeline: layer i is enabled on cycles rs[i]..rs[i]+rd[i].
    function automatic int layer_at(input int c);
        for (int i = 0; i < NL; i++)
            if (c >= rs[i] && c <= rs[i] + rd[i]) return i;
        return -1;
    endfunction

    function automatic bit idle_at(input int c);
        return (c < 1) || (c > r_end);
    endfunction

    function automatic int cur_at(input int c);
        int r = 0;
        for (int i = 0; i < NL; i++)
            if (c >= rs[i]) r = i;
        return r;
    endfunction

    task automatic do_run(input int d0, input int d1, input int d2,
                          input bit inj, input bit eng_rand);
        logic [NL-1:0] obs;
        int            rise[NL];
        logic          pw;
        int            lj;
        int            lc;
        int            c;
        rd[0] = d0;
        rd[1] = d1;
        rd[2] = d2;
        rs[0] = 1;
        for (int i = 1; i < NL; i++)
            rs[i] = rs[i-1] + rd[i-1] + 1 + GAP;
        r_end = rs[NL-1] + rd[NL-1];
        obs = layer_en;
        for (int i = 0; i < NL; i++) rise[i] = 0;
        for (int j = 0; j <= r_end + 2; j++) begin
            start = (j == 0);
            bus.host_we = ($urandom_range(0, 3) == 0);
            if (j == 0 || (!inj && !idle_at(j))) bus.host_we = 1'b0;
            if (inj && j == 1) bus.host_we = 1'b1;
            bus.host_addr = $urandom;
            bus.host_din = DW'($urandom);
            eng_we = eng_rand ? NL'($urandom) : '0;
            for (int i = 0; i < NL; i++) begin
                eng_addr[i*AW +: AW] = $urandom;
                eng_din[i*DW +: DW] = DW'($urandom);
                layer_fin[i] = obs[i] && (j - rise[i] >= rd[i]);
            end
            lj = layer_at(j);
            pw = 1'b0;
            if (idle_at(j)) begin
                pw = bus.host_we;
                if (pw) begin
                    exp_addr = bus.host_addr;
                    exp_din = bus.host_din;
                end
            end else if (lj >= 0) begin
                pw = eng_we[lj];
                if (pw) begin
                    exp_addr = eng_addr[lj*AW +: AW];
                    exp_din = eng_din[lj*DW +: DW];
                end
            end
            if (bus.host_we && !idle_at(j)) exp_drop = 1'b1;
            step();
            c = j + 1;
            lc = layer_at(c);
            chk("run_en", layer_en, (lc >= 0) ? (64'd1 << lc) : 64'd0);
            chk("run_busy", busy, (c >= 1 && c <= r_end) ? 1 : 0);
            chk("run_done", done, (c == r_end + 1) ? 1 : 0);
            chk("run_cur", cur_layer, cur_at(c));
            chk("run_bwe", bus.buf_we, pw);
            chk("run_baddr", bus.buf_addr, exp_addr);
            chk("run_bdin", bus.buf_din, exp_din);
            chk("run_drop", host_drop, exp_drop);
            chk("run_err", err, 0);
            for (int i = 0; i < NL; i++)
                if (layer_en[i] && !obs[i]) rise[i] = c;
            obs = layer_en;
        end
        start = 1'b0;
        bus.host_we = 1'b0;
        eng_we = '0;
        layer_fin = '0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_drop = 1'b0;
        chk("ab_err", err, 0);
        chk("ab_drop", host_drop, 0);
        chk("ab_cur", cur_layer, 0);
        chk("ab_en", layer_en, 0);
        chk("ab_busy", busy, 0);
    endtask

    initial begin
        int n;
        int k;
        bus.host_we = 1'b0;
        bus.host_addr = '0;
        bus.host_din = '0;
        repeat (2) step();
        chk("rst_en", layer_en, 0);
        chk("rst_cur", cur_layer, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_drop", host_drop, 0);
        chk("rst_bwe", bus.buf_we, 0);
        chk("rst_baddr", bus.buf_addr, 0);
        chk("rst_bdin", bus.buf_din, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6144; i++) begin
            bus.host_we = 1'b1;
            bus.host_addr = AW'(i);
            bus.host_din = DW'(i + 10000);
            step();
            chk("hw_we", bus.buf_we, 1);
            chk("hw_addr", bus.buf_addr, i);
            chk("hw_din", bus.buf_din, i + 10000);
        end
        bus.host_we = 1'b0;
        step();
        exp_addr = 6143;
        exp_din = 16143;
        chk("hw_idle_we", bus.buf_we, 0);
        chk("hw_hold_addr", bus.buf_addr, exp_addr);
        chk("hw_hold_din", bus.buf_din, exp_din);
        chk("hw_nodrop", host_drop, 0);

        start = 1'b1;
        bus.host_we = 1'b1;
        bus.host_addr = 32'h55;
        bus.host_din = 16'h1234;
        step();
        start = 1'b0;
        bus.host_we = 1'b0;
        exp_addr = 32'h55;
        exp_din = 16'h1234;
        chk("ign_busy", busy, 0);
        chk("ign_en", layer_en, 0);
        chk("ign_bwe", bus.buf_we, 1);
        chk("ign_baddr", bus.buf_addr, exp_addr);
        step();
        chk("ign_busy2", busy, 0);

        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("prio_busy", busy, 0);
        chk("prio_en", layer_en, 0);

        do_run(50, 50, 50, 1'b0, 1'b1);
        do_run($urandom_range(1, 60), $urandom_range(1, 60),
               $urandom_range(1, 60), 1'b1, 1'b1);
        chk("drop_set", host_drop, 1);
        do_abort();

        start = 1'b1;
        step();
        start = 1'b0;
        chk("e_en0", layer_en, 3'b001);
        k = $urandom_range(1, 20);
        repeat (k) step();
        layer_fin = 3'b010;
        step();
        layer_fin = '0;
        chk("e_err", err, 1);
        chk("e_en", layer_en, 0);
        chk("e_busy", busy, 0);
        eng_we = 3'b111;
        repeat (5) step();
        chk("e_hold", err, 1);
        chk("e_hold_en", layer_en, 0);
        chk("e_bwe", bus.buf_we, 0);
        eng_we = '0;
        do_abort();

        start = 1'b1;
        step();
        start = 1'b0;
        chk("to_run", layer_en, 3'b001);
        repeat (TO - 1) step();
        chk("to_before", err, 0);
        step();
        chk("to_err", err, 1);
        chk("to_en", layer_en, 0);
        do_abort();

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        layer_fin = 3'b001;
        step();
        layer_fin = '0;
        n = 0;
        while (layer_en !== 3'b010 && n < 20) begin
            step();
            n++;
        end
        chk("rm_l1", layer_en, 3'b010);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rm_en", layer_en, 0);
        chk("rm_done", done, 0);
        chk("rm_busy", busy, 0);
        chk("rm_cur", cur_layer, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rm_done2", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = '0;
        exp_din = '0;
        exp_drop = 1'b0;
        step();
        do_run($urandom_range(1, 40), $urandom_range(1, 40),
               $urandom_range(1, 40), 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3, the number of layer engines sequenced in order 0..NUM_LAYERS-1.
REQ-002 SHALL have parameter ADDR_W, default 32, the feature-buffer address width.
REQ-003 SHALL have parameter DATA_W, default 16, the feature-buffer data width.
REQ-004 SHALL have parameter GAP_CYCLES, default 4, the idle cycles between consecutive layers.
REQ-005 SHALL have parameter TIMEOUT, default 65535, the maximum cycles one layer may run.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk, input, 1, system clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, single-cycle run request.
REQ-010 SHALL have port abort, input, 1, forces return to IDLE.
REQ-011 SHALL have port host_we, input, 1, host buffer-load write strobe.
REQ-012 SHALL have port host_addr, input, ADDR_W, host write address.
REQ-013 SHALL have port host_din, input, DATA_W, host write data.
REQ-014 SHALL have port eng_we, input, NUM_LAYERS, per-engine write strobe.
REQ-015 SHALL have port eng_addr, input, ADDR_W*NUM_LAYERS, packed engine write addresses, engine i at slice i.
REQ-016 SHALL have port eng_din, input, DATA_W*NUM_LAYERS, packed engine write data.
REQ-017 SHALL have port layer_fin, input, NUM_LAYERS, per-engine work_finished level.
REQ-018 SHALL have port layer_en, output, NUM_LAYERS, one-hot engine enable.
REQ-019 SHALL have port buf_we, output, 1, muxed buffer write strobe.
REQ-020 SHALL have port buf_addr, output, ADDR_W, muxed buffer write address.
REQ-021 SHALL have port buf_din, output, DATA_W, muxed buffer write data.
REQ-022 SHALL have port cur_layer, output, clog2(NUM_LAYERS), index of the active layer.
REQ-023 SHALL have port busy, output, 1, high in RUN and GAP.
REQ-024 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-025 SHALL have port err, output, 1, sticky error flag.
REQ-026 SHALL have port host_drop, output, 1, sticky flag: a host write was discarded.

Function
REQ-027 SHALL implement FSM states IDLE, RUN, GAP, ERR.
REQ-028 IDLE SHALL go to RUN with cur_layer=0 on start=1 and host_we=0; start with host_we=1 SHALL be ignored.
REQ-029 RUN SHALL drive layer_en one-hot at cur_layer, registered, first asserted the cycle after entry.
REQ-030 RUN with layer_fin[cur_layer]=1 SHALL clear layer_en next cycle, then go to GAP, or to IDLE with done=1 for one cycle when cur_layer=NUM_LAYERS-1.
REQ-031 GAP SHALL hold layer_en=0 for exactly GAP_CYCLES cycles, then increment cur_layer and re-enter RUN.
REQ-032 layer_fin asserted for any index other than cur_layer in RUN SHALL set err and go to ERR.
REQ-033 The watchdog SHALL clear on RUN entry and count RUN cycles; reaching TIMEOUT SHALL set err and go to ERR.
REQ-034 ERR SHALL hold layer_en=0 and buf_we=0 until abort.
REQ-035 abort SHALL move any state to IDLE next cycle, clearing layer_en, err, host_drop and cur_layer; abort has priority over start and layer_fin.
REQ-036 The write-port mux SHALL select host in IDLE, eng[cur_layer] in RUN, and no source in GAP/ERR, with buf_* registered (1-cycle latency).
REQ-037 A host_we occurring outside IDLE SHALL be discarded and SHALL set host_drop.
REQ-038 buf_addr and buf_din SHALL hold their last value when buf_we=0.

Reset
REQ-039 rst_n=0 SHALL asynchronously force IDLE with all outputs 0, cur_layer=0, and watchdog=0.
REQ-040 Reset mid-RUN SHALL drop layer_en within the reset assertion, with no done pulse.

Structure
REQ-041 Package cnn_pkg SHALL hold the state encoding, DATA_W/ADDR_W defaults, and the default GAP_CYCLES/TIMEOUT constants.
REQ-042 The watchdog SHALL be a sub-module seq_wdog (clear, enable, terminal-count output).

Verification (NUM_LAYERS=3, GAP_CYCLES=4, TIMEOUT=1000)
REQ-043 Host writes addr 0..6143, data i+10000 in IDLE -> buf_we/addr/din mirror the host one cycle later, with no drops.
REQ-044 start, with each engine raising fin 50 cycles after its enable -> layer_en 001, 010, 100 with 4-cycle gaps; done pulses once; busy falls with done.
REQ-045 Engine 1 raises fin while layer 0 is active -> err=1, state ERR, layer_en=0; abort -> IDLE and err=0.
REQ-046 Engine never finishes -> err=1 exactly 1000 cycles after RUN entry.
REQ-047 host_we during RUN -> no buffer write from the host, and host_drop=1.
REQ-048 rst_n low mid-layer-1 -> immediate layer_en=0, done=0; after release, start reruns from layer 0.
